tone_scheduler: RTL and testbench

Round-robin scheduler that shares the single piano-tone generator among up to NUM_REQ note requesters, such as drum-pad channels and ROM playback. It accepts one request at a time and latches its note code and duration. It drives the generator's 8-bit note input for the requested time, then a short silent articulation gap, and reports completion back to the owning requester. It sits between the requesters and the tone generator's note input (octave*12+semitone encoding, 0 = silence).

---
 rtl/tone_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 28 ++
 rtl/tone_scheduler.sv | 150 +++++++++++++++
 tb/tb_tone_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the tone scheduling path: FSM states, note codes, sanitising.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package tone_pkg;

    localparam int NOTE_W = 8;

    localparam logic [NOTE_W-1:0] NOTE_REST = 8'd0;
    localparam logic [NOTE_W-1:0] NOTE_MAX  = 8'd63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Codes above the generator's range become a rest; 0 already is one.
    function automatic logic [NOTE_W-1:0] sanitise_note(input logic [NOTE_W-1:0] code);
        return (code > NOTE_MAX) ? NOTE_REST : code;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider emitting a one-cycle tick every TICK_DIV cycles.
// Latency: first tick TICK_DIV cycles after clr is released (count runs 0..TICK_DIV-1).
// Backpressure: none; clr restarts the count synchronously.
module tick_prescaler #(
    parameter int TICK_DIV = 500000
) (
    input  logic sysclk,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count up and wrap at the last value; clr pins the count to zero.
    always_ff @(posedge sysclk) begin
        if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/tone_scheduler.sv
// Round-robin owner of the tone generator: grants one requester, plays its note, then a silent gap.
// Latency: ack/note/busy/owner one cycle after an IDLE cycle with req; done on the first IDLE cycle.
// Backpressure: requesters hold req until ack; no arbitration happens while PLAY or GAP.
module tone_scheduler
    import tone_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DUR_W     = 8,
    parameter int TICK_DIV  = 500000,
    parameter int GAP_TICKS = 2
) (
    input  logic                       sysclk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*8-1:0]       req_note,
    input  logic [NUM_REQ*DUR_W-1:0]   req_dur,
    input  logic                       stop,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         done,
    output logic [7:0]                 note,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    localparam int OW    = $clog2(NUM_REQ);
    localparam int GW    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int CNT_W = (DUR_W > GW) ? DUR_W : GW;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [OW-1:0]      rr_ptr;
    logic               tick;
    logic               presc_clr;

    logic [NOTE_W-1:0]  note_arr [NUM_REQ];
    logic [DUR_W-1:0]   dur_arr  [NUM_REQ];

    logic               found;
    logic [OW-1:0]      grant_idx;
    logic [OW-1:0]      next_ptr;
    logic [NOTE_W-1:0]  sel_note;
    logic [DUR_W-1:0]   sel_dur;
    logic [OW:0]        pos_sum;
    logic [OW-1:0]      pos;

    // The prescaler sits at zero in IDLE so a note starts on a fresh tick boundary.
    assign presc_clr = reset || (state == IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .sysclk (sysclk),
        .clr    (presc_clr),
        .tick   (tick)
    );

    // Split the flat note/duration buses into per-requester fields.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            note_arr[k] = req_note[k*NOTE_W +: NOTE_W];
            dur_arr[k]  = req_dur[k*DUR_W +: DUR_W];
        end
    end

    // Round-robin search starting at rr_ptr; first raised req wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        sel_note  = '0;
        sel_dur   = '0;
        pos_sum   = '0;
        pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_sum = {1'b0, rr_ptr} + (OW+1)'(k);
            if (pos_sum >= (OW+1)'(NUM_REQ)) begin
                pos_sum = pos_sum - (OW+1)'(NUM_REQ);
            end
            pos = pos_sum[OW-1:0];
            if (!found && req[pos]) begin
                found     = 1'b1;
                grant_idx = pos;
                sel_note  = note_arr[pos];
                sel_dur   = dur_arr[pos];
            end
        end
        next_ptr = (grant_idx == OW'(NUM_REQ - 1)) ? '0 : grant_idx + OW'(1);
    end

    // Scheduler FSM; every output is a register updated here.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            rr_ptr <= '0;
            owner  <= '0;
            note   <= NOTE_REST;
            busy   <= 1'b0;
            ack    <= '0;
            done   <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        ack[grant_idx] <= 1'b1;
                        owner          <= grant_idx;
                        rr_ptr         <= next_ptr;
                        note           <= sanitise_note(sel_note);
                        cnt            <= (sel_dur == '0) ? CNT_W'(1) : CNT_W'(sel_dur);
                        busy           <= 1'b1;
                        state          <= PLAY;
                    end
                end
                PLAY: begin
                    if (stop || (tick && cnt == CNT_W'(1) && GAP_TICKS == 0)) begin
                        note        <= NOTE_REST;
                        done[owner] <= 1'b1;
                        busy        <= 1'b0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else if (tick) begin
                        if (cnt == CNT_W'(1)) begin
                            note  <= NOTE_REST;
                            cnt   <= CNT_W'(GAP_TICKS);
                            state <= GAP;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (stop || (tick && cnt == CNT_W'(1))) begin
                        note        <= NOTE_REST;
                        done[owner] <= 1'b1;
                        busy        <= 1'b0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else if (tick) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed bench for tone_scheduler with TICK_DIV=4, GAP_TICKS=1, NUM_REQ=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_tone_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int DUR_W     = 8;
    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 1;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        stop;
    logic [3:0]  req;
    logic [31:0] req_note;
    logic [31:0] req_dur;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic [7:0]  note;
    logic        busy;
    logic [1:0]  owner;

    int vectors     = 0;
    int miscompares = 0;

    always #5 sysclk = ~sysclk;

    tone_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .DUR_W     (DUR_W),
        .TICK_DIV  (TICK_DIV),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .req      (req),
        .req_note (req_note),
        .req_dur  (req_dur),
        .stop     (stop),
        .ack      (ack),
        .done     (done),
        .note     (note),
        .busy     (busy),
        .owner    (owner)
    );

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic run_until_ack(input int budget, output logic [3:0] got, output int n);
        got = 4'b0000;
        n   = 0;
        while (got == 4'b0000 && n < budget) begin
            step();
            n++;
            got = ack;
        end
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        timed_out = (busy !== 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; stop = 1'b0; req = 4'b0000; req_note = '0; req_dur = '0;
        step(); step();
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack: got %b want 0000", ack); end
        vectors++; if (done !== 4'b0000) begin miscompares++; $display("FAIL reset_done: got %b want 0000", done); end
        vectors++; if (note !== 8'd0) begin miscompares++; $display("FAIL reset_note: got %0d want 0", note); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (owner !== 2'd0) begin miscompares++; $display("FAIL reset_owner: got %0d want 0", owner); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        req_note[7:0] = 8'd24; req_dur[7:0] = 8'd3; req = 4'b0001;
        step();
        vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL single_ack: got %b want 0001", ack); end
        vectors++; if (note !== 8'd24) begin miscompares++; $display("FAIL single_note0: got %0d want 24", note); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
        vectors++; if (owner !== 2'd0) begin miscompares++; $display("FAIL single_owner: got %0d want 0", owner); end
        // Changing the fields after the grant must not affect the note.
        req = 4'b0000; req_note[7:0] = 8'd99; req_dur[7:0] = 8'd0;
        for (int i = 1; i < 12; i++) begin
            step();
            vectors++;
            if (note !== 8'd24 || done !== 4'b0000) begin
                miscompares++; $display("FAIL single_play[%0d]: note=%0d done=%b want 24/0000", i, note, done);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (note !== 8'd0 || busy !== 1'b1 || done !== 4'b0000) begin
                miscompares++; $display("FAIL single_gap[%0d]: note=%0d busy=%b done=%b want 0/1/0000", i, note, busy, done);
            end
        end
        step();
        vectors++; if (done !== 4'b0001) begin miscompares++; $display("FAIL single_done: got %b want 0001", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] got;
        logic [3:0] exp;
        int n;
        bit to;
        reset = 1'b1; step(); reset = 1'b0;
        req_note = {8'd13, 8'd12, 8'd11, 8'd10};
        req_dur  = {8'd1, 8'd1, 8'd1, 8'd1};
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            run_until_ack(40, got, n);
            exp = 4'b0001 << k;
            vectors++; if (got !== exp) begin miscompares++; $display("FAIL rr_order[%0d]: ack=%b want %b", k, got, exp); end
            vectors++; if (note !== 8'(10 + k)) begin miscompares++; $display("FAIL rr_note[%0d]: got %0d want %0d", k, note, 10 + k); end
            if (k == 0) begin
                vectors++; if (n !== 1) begin miscompares++; $display("FAIL rr_latency: got %0d cycles want 1", n); end
            end
            req = req & ~got;
        end
        wait_idle(40, to);
        vectors++; if (to) begin miscompares++; $display("FAIL rr_idle: busy=%b want 0", busy); end
        req = 4'b0101;
        run_until_ack(40, got, n);
        vectors++; if (got !== 4'b0001) begin miscompares++; $display("FAIL rr_wrap_first: ack=%b want 0001", got); end
        req = req & ~got;
        run_until_ack(40, got, n);
        vectors++; if (got !== 4'b0100) begin miscompares++; $display("FAIL rr_wrap_second: ack=%b want 0100", got); end
        req = req & ~got;
        wait_idle(40, to);
    endtask

    task automatic test_abort();
        req_note[15:8] = 8'd40; req_dur[15:8] = 8'd5; req = 4'b0010;
        step();
        vectors++; if (ack !== 4'b0010) begin miscompares++; $display("FAIL abort_ack: got %b want 0010", ack); end
        req = 4'b0000;
        step(); step(); step(); step();
        vectors++; if (note !== 8'd40) begin miscompares++; $display("FAIL abort_pre_note: got %0d want 40", note); end
        stop = 1'b1;
        step();
        vectors++; if (note !== 8'd0) begin miscompares++; $display("FAIL abort_note: got %0d want 0", note); end
        vectors++; if (done !== 4'b0010) begin miscompares++; $display("FAIL abort_done: got %b want 0010", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
        stop = 1'b0;
        step();
        vectors++; if (done !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
            miscompares++; $display("FAIL abort_after: done=%b ack=%b busy=%b want 0000/0000/0", done, ack, busy);
        end
    endtask

    task automatic test_edge_codes();
        bit to;
        // Zero duration plays one tick.
        req_note[7:0] = 8'd30; req_dur[7:0] = 8'd0; req = 4'b0001;
        step();
        vectors++; if (ack !== 4'b0001 || note !== 8'd30) begin miscompares++; $display("FAIL dur0_start: ack=%b note=%0d want 0001/30", ack, note); end
        req = 4'b0000;
        for (int i = 1; i < 4; i++) begin
            step();
            vectors++; if (note !== 8'd30) begin miscompares++; $display("FAIL dur0_play[%0d]: got %0d want 30", i, note); end
        end
        step();
        vectors++; if (note !== 8'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL dur0_end: note=%0d busy=%b want 0/1", note, busy); end
        wait_idle(20, to);
        vectors++; if (to) begin miscompares++; $display("FAIL dur0_idle: busy=%b want 0", busy); end
        // Out-of-range code rests for the whole duration and still completes.
        req_note[23:16] = 8'h40; req_dur[23:16] = 8'd2; req = 4'b0100;
        step();
        vectors++; if (ack !== 4'b0100 || note !== 8'd0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL code64_start: ack=%b note=%0d busy=%b want 0100/0/1", ack, note, busy);
        end
        req = 4'b0000;
        for (int i = 1; i < 12; i++) begin
            step();
            vectors++; if (note !== 8'd0 || done !== 4'b0000) begin miscompares++; $display("FAIL code64_rest[%0d]: note=%0d done=%b want 0/0000", i, note, done); end
        end
        step();
        vectors++; if (done !== 4'b0100 || busy !== 1'b0) begin miscompares++; $display("FAIL code64_done: done=%b busy=%b want 0100/0", done, busy); end
        // Highest valid code passes unchanged.
        req_note[15:8] = 8'd63; req_dur[15:8] = 8'd1; req = 4'b0010;
        step();
        vectors++; if (note !== 8'd63) begin miscompares++; $display("FAIL code63: got %0d want 63", note); end
        req = 4'b0000;
        wait_idle(20, to);
        req_note[31:24] = 8'd255; req_dur[31:24] = 8'd1; req = 4'b1000;
        step();
        vectors++; if (note !== 8'd0 || ack !== 4'b1000) begin miscompares++; $display("FAIL code255: note=%0d ack=%b want 0/1000", note, ack); end
        req = 4'b0000;
        wait_idle(20, to);
    endtask

    task automatic test_reset_mid_play();
        req_note[23:16] = 8'd50; req_dur[23:16] = 8'd4; req = 4'b0100;
        step();
        vectors++; if (ack !== 4'b0100 || note !== 8'd50 || owner !== 2'd2) begin
            miscompares++; $display("FAIL rst_mid_start: ack=%b note=%0d owner=%0d want 0100/50/2", ack, note, owner);
        end
        step(); step(); step();
        reset = 1'b1;
        step();
        vectors++; if (note !== 8'd0) begin miscompares++; $display("FAIL rst_mid_note: got %0d want 0", note); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        vectors++; if (owner !== 2'd0) begin miscompares++; $display("FAIL rst_mid_owner: got %0d want 0", owner); end
        vectors++; if (done !== 4'b0000 || ack !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_pulses: done=%b ack=%b want 0000/0000", done, ack); end
        reset = 1'b0;
        step();
        vectors++; if (ack !== 4'b0100 || done !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_regrant: ack=%b done=%b want 0100/0000", ack, done); end
        vectors++; if (owner !== 2'd2 || note !== 8'd50) begin miscompares++; $display("FAIL rst_mid_owner2: owner=%0d note=%0d want 2/50", owner, note); end
        req = 4'b0000;
    endtask

    task automatic test_withdrawn_and_held();
        logic [3:0] got;
        int n;
        bit to;
        bit saw3;
        int extra;
        wait_idle(40, to);
        req_note[7:0] = 8'd20; req_dur[7:0] = 8'd2; req = 4'b0001;
        step();
        vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL withdraw_ack0: got %b want 0001", ack); end
        req = 4'b0000;
        step(); step();
        req = 4'b1000;
        step();
        req = 4'b0000;
        saw3 = 1'b0;
        extra = 0;
        for (int i = 0; i < 40 && extra < 4; i++) begin
            step();
            if (ack[3] === 1'b1) saw3 = 1'b1;
            if (busy === 1'b0) extra++;
        end
        vectors++; if (saw3 !== 1'b0 || extra < 4) begin miscompares++; $display("FAIL withdraw_req3: acked=%b idle_cycles=%0d want 0/4", saw3, extra); end
        // A requester that keeps req high is served again after its done.
        req_note[15:8] = 8'd21; req_dur[15:8] = 8'd1; req = 4'b0010;
        step();
        vectors++; if (ack !== 4'b0010) begin miscompares++; $display("FAIL held_ack: got %b want 0010", ack); end
        run_until_ack(40, got, n);
        vectors++; if (got !== 4'b0010) begin miscompares++; $display("FAIL held_regrant: ack=%b want 0010", got); end
        vectors++; if (n !== 9) begin miscompares++; $display("FAIL held_spacing: got %0d cycles want 9", n); end
        req = 4'b0000;
        wait_idle(40, to);
        vectors++; if (to) begin miscompares++; $display("FAIL held_idle: busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_edge_codes();
        test_reset_mid_play();
        test_withdrawn_and_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
